fp32_mul_post: RTL

- Output stage of the single-precision multiply datapath. Consumes the raw 48-bit mantissa product from the 24x24 array multiplier, together with the original IEEE-754 operands.
- Produces a packed, correctly rounded fp32 result.
- Two-stage valid/ready pipeline that sits between the combinational multiplier and the result consumer.

---
 rtl/fp32_mul_post_if.sv | 31 +++
 rtl/fp32_mul_post.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fp32_mul_post_if.sv
// Handshake and data bundle for the fp32 multiply output stage.
// out_flags exists only when FP_MUL_FLAGS_EN is defined.
interface fp32_mul_post_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [47:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  modport master (
    output in_valid, in_a, in_b, in_prod, out_ready,
    input  in_ready, out_valid, out_res
`ifdef FP_MUL_FLAGS_EN
    , input out_flags
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_prod, out_ready,
    output in_ready, out_valid, out_res
`ifdef FP_MUL_FLAGS_EN
    , output out_flags
`endif
  );
endinterface

// File: rtl/fp32_mul_post.sv
// fp32 multiply output stage: classify/normalise (S1), round/pack (S2), valid/ready.
// Optional macro FP_MUL_FLAGS_EN adds out_flags = {invalid, overflow, underflow, inexact}.
module fp32_mul_post #(
  parameter bit          RNE  = 1'b1,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input logic            clk,
  input logic            rst,
  fp32_mul_post_if.slave io
);

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        zero;
`ifdef FP_MUL_FLAGS_EN
    logic        inv;
`endif
    logic [22:0] mant;
    logic        g;
    logic        st;
    logic [9:0]  e;
  } s1_t;

  s1_t         s1_q, s1_d, s1_new;
  logic        s1_v_q, s1_v_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_res_q, out_res_d, res;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  out_flags_q, out_flags_d, flg;
`endif

  logic        s2_load, s1_load;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        inc, carry, ovf, unf;
  logic [22:0] mant_r;
  logic [9:0]  e_r;

  assign s2_load     = !out_valid_q || io.out_ready;
  assign s1_load     = !s1_v_q || s2_load;
  assign io.in_ready = s1_load;
  assign io.out_valid = out_valid_q;
  assign io.out_res   = out_res_q;
`ifdef FP_MUL_FLAGS_EN
  assign io.out_flags = out_flags_q;
`endif

  always_comb begin
    ea = io.in_a[30:23];
    eb = io.in_b[30:23];
    fa = io.in_a[22:0];
    fb = io.in_b[22:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);

    s1_new      = '0;
    s1_new.sign = io.in_a[31] ^ io.in_b[31];
    s1_new.nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    s1_new.inf  = a_inf || b_inf;
    s1_new.zero = a_zero || b_zero;
`ifdef FP_MUL_FLAGS_EN
    s1_new.inv  = (a_inf && b_zero) || (b_inf && a_zero) ||
                  (a_nan && !fa[22]) || (b_nan && !fb[22]);
`endif
    if (io.in_prod[47]) begin
      s1_new.mant = io.in_prod[46:24];
      s1_new.g    = io.in_prod[23];
      s1_new.st   = |io.in_prod[22:0];
    end else begin
      s1_new.mant = io.in_prod[45:23];
      s1_new.g    = io.in_prod[22];
      s1_new.st   = |io.in_prod[21:0];
    end
    // Modular 10-bit sum: reads back as two's complement of ea+eb-127+n.
    s1_new.e = {2'b00, ea} + {2'b00, eb} + {9'd0, io.in_prod[47]} - 10'd127;

    s1_v_d = s1_load ? io.in_valid : s1_v_q;
    s1_d   = (s1_load && io.in_valid) ? s1_new : s1_q;
  end

  always_comb begin
    inc             = RNE && s1_q.g && (s1_q.st || s1_q.mant[0]);
    {carry, mant_r} = {1'b0, s1_q.mant} + {23'd0, inc};
    e_r             = s1_q.e + {9'd0, carry};
    ovf             = !e_r[9] && (e_r >= 10'd255);
    unf             = e_r[9] || (e_r == 10'd0);

    res = {s1_q.sign, e_r[7:0], mant_r};
`ifdef FP_MUL_FLAGS_EN
    flg = {1'b0, 1'b0, 1'b0, s1_q.g || s1_q.st};
`endif
    if (s1_q.nan) begin
      res = QNAN;
`ifdef FP_MUL_FLAGS_EN
      flg = {s1_q.inv, 3'b000};
`endif
    end else if (s1_q.inf) begin
      res = {s1_q.sign, 8'hFF, 23'd0};
`ifdef FP_MUL_FLAGS_EN
      flg = '0;
`endif
    end else if (s1_q.zero) begin
      res = {s1_q.sign, 31'd0};
`ifdef FP_MUL_FLAGS_EN
      flg = '0;
`endif
    end else if (ovf) begin
      res = RNE ? {s1_q.sign, 8'hFF, 23'd0} : {s1_q.sign, 31'h7F7FFFFF};
`ifdef FP_MUL_FLAGS_EN
      flg = 4'b0101;
`endif
    end else if (unf) begin
      res = {s1_q.sign, 31'd0};
`ifdef FP_MUL_FLAGS_EN
      flg = 4'b0011;
`endif
    end

    out_valid_d = s2_load ? s1_v_q : out_valid_q;
    out_res_d   = (s2_load && s1_v_q) ? res : out_res_q;
`ifdef FP_MUL_FLAGS_EN
    out_flags_d = (s2_load && s1_v_q) ? flg : out_flags_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= '0;
      s1_q        <= '0;
      out_valid_q <= '0;
      out_res_q   <= '0;
`ifdef FP_MUL_FLAGS_EN
      out_flags_q <= '0;
`endif
    end else begin
      s1_v_q      <= s1_v_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
`ifdef FP_MUL_FLAGS_EN
      out_flags_q <= out_flags_d;
`endif
    end
  end

endmodule
